// File: rtl/mp_reg_file_sb_pkg.sv
// Shared defaults and constants for the multi-port register file with busy scoreboard.
// Optional write-through forwarding is enabled by defining REG_FILE_BYPASS_EN.
package mp_reg_file_sb_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 5;
  localparam int NRD_DEF    = 2;
  localparam int ZERO_REG   = 0;
  localparam int DEPTH_DEF  = 1 << ADDR_W_DEF;

  function automatic int depth_of(input int addr_w);
    return 1 << addr_w;
  endfunction

endpackage

// File: rtl/mp_reg_file_sb_scoreboard.sv
// Per-register busy scoreboard: issue sets, writeback clears, and the new producer wins on a tie.
// REG_FILE_BYPASS_EN forwards a same-cycle writeback clear to the read-port busy flags.
module rf_scoreboard
  import mp_reg_file_sb_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int NRD    = NRD_DEF
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  we0,
  input  logic [ADDR_W-1:0]     wa0,
  input  logic                  we1,
  input  logic [ADDR_W-1:0]     wa1,
  input  logic                  iss_vld,
  input  logic [ADDR_W-1:0]     iss_wa,
  input  logic [NRD*ADDR_W-1:0] ra,
  output logic [NRD-1:0]        rd_busy,
  output logic                  iss_waw
);

  localparam int DEPTH = depth_of(ADDR_W);
  localparam logic [ADDR_W-1:0] ZA = ADDR_W'(ZERO_REG);

  logic [DEPTH-1:0] busy;
  logic [DEPTH-1:0] busy_nxt;
  logic             clr0;
  logic             clr1;
  logic             set;

  assign clr0 = we0 && (wa0 != ZA);
  assign clr1 = we1 && (wa1 != ZA);
  assign set  = iss_vld && (iss_wa != ZA);

  // Set is applied last so an issue overrides a writeback to the same register.
  always_comb begin
    busy_nxt = busy;
    if (clr0) busy_nxt[wa0] = 1'b0;
    if (clr1) busy_nxt[wa1] = 1'b0;
    if (set)  busy_nxt[iss_wa] = 1'b1;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) busy <= '0;
    else       busy <= busy_nxt;
  end

  assign iss_waw = (iss_wa != ZA) && busy[iss_wa];

  for (genvar k = 0; k < NRD; k++) begin : g_port
    logic [ADDR_W-1:0] a;
    assign a = ra[k*ADDR_W +: ADDR_W];
`ifdef REG_FILE_BYPASS_EN
    logic fwd_clr;
    assign fwd_clr = ((clr0 && (wa0 == a)) || (clr1 && (wa1 == a)))
                     && !(set && (iss_wa == a));
    assign rd_busy[k] = (a != ZA) && busy[a] && !fwd_clr;
`else
    assign rd_busy[k] = (a != ZA) && busy[a];
`endif
  end

endmodule

// File: rtl/mp_reg_file_sb.sv
// Multi-port register file with two write ports, x0 hardwired to zero and a busy scoreboard.
// REG_FILE_BYPASS_EN adds write-through forwarding on the read ports; dbg_rd is never forwarded.
module mp_reg_file_sb
  import mp_reg_file_sb_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int NRD    = NRD_DEF
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic [NRD*ADDR_W-1:0] ra,
  output logic [NRD*DATA_W-1:0] rd,
  output logic [NRD-1:0]        rd_busy,
  input  logic                  we0,
  input  logic [ADDR_W-1:0]     wa0,
  input  logic [DATA_W-1:0]     wd0,
  input  logic                  we1,
  input  logic [ADDR_W-1:0]     wa1,
  input  logic [DATA_W-1:0]     wd1,
  input  logic                  iss_vld,
  input  logic [ADDR_W-1:0]     iss_wa,
  output logic                  iss_waw,
  input  logic [ADDR_W-1:0]     dbg_ra,
  output logic [DATA_W-1:0]     dbg_rd
);

  localparam int DEPTH = depth_of(ADDR_W);
  localparam logic [ADDR_W-1:0] ZA = ADDR_W'(ZERO_REG);

  logic [DATA_W-1:0] mem [DEPTH];

  // Port 1 is assigned last so it wins a same-address conflict.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (we0 && (wa0 != ZA)) mem[wa0] <= wd0;
      if (we1 && (wa1 != ZA)) mem[wa1] <= wd1;
    end
  end

  for (genvar k = 0; k < NRD; k++) begin : g_rd
    logic [ADDR_W-1:0] a;
    logic [DATA_W-1:0] stored;
    assign a      = ra[k*ADDR_W +: ADDR_W];
    assign stored = (a == ZA) ? '0 : mem[a];
`ifdef REG_FILE_BYPASS_EN
    assign rd[k*DATA_W +: DATA_W] =
      (we1 && (wa1 != ZA) && (wa1 == a)) ? wd1 :
      (we0 && (wa0 != ZA) && (wa0 == a)) ? wd0 : stored;
`else
    assign rd[k*DATA_W +: DATA_W] = stored;
`endif
  end

  assign dbg_rd = (dbg_ra == ZA) ? '0 : mem[dbg_ra];

  rf_scoreboard #(
    .ADDR_W (ADDR_W),
    .NRD    (NRD)
  ) u_sb (
    .clk     (clk),
    .rstn    (rstn),
    .we0     (we0),
    .wa0     (wa0),
    .we1     (we1),
    .wa1     (wa1),
    .iss_vld (iss_vld),
    .iss_wa  (iss_wa),
    .ra      (ra),
    .rd_busy (rd_busy),
    .iss_waw (iss_waw)
  );

endmodule

// File: tb/tb_mp_reg_file_sb.sv
// Bench for mp_reg_file_sb: directed table on the default build plus random traffic on a 16/4/3 instance.
module tb_mp_reg_file_sb;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rstn;

  // Instance A: default parameters
  logic [9:0]  a_ra;
  logic [63:0] a_rd;
  logic [1:0]  a_rd_busy;
  logic        a_we0, a_we1, a_iss_vld, a_iss_waw;
  logic [4:0]  a_wa0, a_wa1, a_iss_wa, a_dbg_ra;
  logic [31:0] a_wd0, a_wd1, a_dbg_rd;

  // Instance B: DATA_W=16, ADDR_W=4, NRD=3
  logic [11:0] b_ra;
  logic [47:0] b_rd;
  logic [2:0]  b_rd_busy;
  logic        b_we0, b_we1, b_iss_vld, b_iss_waw;
  logic [3:0]  b_wa0, b_wa1, b_iss_wa, b_dbg_ra;
  logic [15:0] b_wd0, b_wd1, b_dbg_rd;

  mp_reg_file_sb dut_a (
    .clk(clk), .rstn(rstn), .ra(a_ra), .rd(a_rd), .rd_busy(a_rd_busy),
    .we0(a_we0), .wa0(a_wa0), .wd0(a_wd0), .we1(a_we1), .wa1(a_wa1), .wd1(a_wd1),
    .iss_vld(a_iss_vld), .iss_wa(a_iss_wa), .iss_waw(a_iss_waw),
    .dbg_ra(a_dbg_ra), .dbg_rd(a_dbg_rd)
  );

  mp_reg_file_sb #(.DATA_W(16), .ADDR_W(4), .NRD(3)) dut_b (
    .clk(clk), .rstn(rstn), .ra(b_ra), .rd(b_rd), .rd_busy(b_rd_busy),
    .we0(b_we0), .wa0(b_wa0), .wd0(b_wd0), .we1(b_we1), .wa1(b_wa1), .wd1(b_wd1),
    .iss_vld(b_iss_vld), .iss_wa(b_iss_wa), .iss_waw(b_iss_waw),
    .dbg_ra(b_dbg_ra), .dbg_rd(b_dbg_rd)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic        we0; logic [4:0] wa0; logic [31:0] wd0;
    logic        we1; logic [4:0] wa1; logic [31:0] wd1;
    logic        iv;  logic [4:0] iwa;
    logic [4:0]  ra0; logic [4:0] ra1; logic [4:0] dra;
    logic [31:0] e_rd0; logic [31:0] e_rd1;
    logic        e_b0;  logic        e_b1;
    logic        e_waw; logic [31:0] e_dbg;
  } vec_t;

  vec_t tbl [13];

  task automatic drive_a(input vec_t r);
    a_we0 = r.we0; a_wa0 = r.wa0; a_wd0 = r.wd0;
    a_we1 = r.we1; a_wa1 = r.wa1; a_wd1 = r.wd1;
    a_iss_vld = r.iv; a_iss_wa = r.iwa;
    a_ra = {r.ra1, r.ra0}; a_dbg_ra = r.dra;
  endtask

  task automatic idle_a(input logic [4:0] ra0, input logic [4:0] ra1,
                        input logic [4:0] dra, input logic [4:0] iwa);
    a_we0 = 0; a_wa0 = 0; a_wd0 = 0; a_we1 = 0; a_wa1 = 0; a_wd1 = 0;
    a_iss_vld = 0; a_iss_wa = iwa; a_ra = {ra1, ra0}; a_dbg_ra = dra;
  endtask

  // Reference model for instance B
  logic [15:0] mm [16];
  bit          bm [16];

  function automatic logic [15:0] m_rd(input logic [3:0] a);
`ifdef REG_FILE_BYPASS_EN
    if (b_we1 && b_wa1 != 0 && b_wa1 == a) return b_wd1;
    if (b_we0 && b_wa0 != 0 && b_wa0 == a) return b_wd0;
`endif
    return (a == 0) ? 16'h0 : mm[a];
  endfunction

  function automatic logic m_busy(input logic [3:0] a);
`ifdef REG_FILE_BYPASS_EN
    if (a != 0 && ((b_we0 && b_wa0 == a) || (b_we1 && b_wa1 == a))
        && !(b_iss_vld && b_iss_wa == a)) return 1'b0;
`endif
    return (a == 0) ? 1'b0 : bm[a];
  endfunction

  logic [31:0] exp_byp;
  logic        exp_bbyp;

  initial begin
    // row: we0 wa0 wd0 | we1 wa1 wd1 | iv iwa | ra0 ra1 dra | rd0 rd1 b0 b1 waw dbg
    tbl[0]  = '{0,0,0,           0,0,0,       0,0, 0,5,7, 0,0,0,0,0,0};
    tbl[1]  = '{1,0,32'hFFFFFFFF,0,0,0,       1,0, 0,0,0, 0,0,0,0,0,0};
    tbl[2]  = '{0,0,0,           0,0,0,       0,0, 0,0,0, 0,0,0,0,0,0};
    tbl[3]  = '{1,7,32'hAAAA,    1,7,32'h5555,0,0, 5,1,7, 0,0,0,0,0,0};
    tbl[4]  = '{0,0,0,           0,0,0,       0,7, 7,0,7, 32'h5555,0,0,0,0,32'h5555};
    tbl[5]  = '{0,0,0,           0,0,0,       1,3, 3,7,0, 0,32'h5555,0,0,0,0};
    tbl[6]  = '{0,0,0,           0,0,0,       0,3, 3,3,0, 0,0,1,1,1,0};
    tbl[7]  = '{1,3,32'h33,      0,0,0,       0,3, 7,0,3, 32'h5555,0,0,0,1,0};
    tbl[8]  = '{0,0,0,           0,0,0,       0,3, 3,7,3, 32'h33,32'h5555,0,0,0,32'h33};
    tbl[9]  = '{0,0,0,           1,3,32'h77,  1,3, 7,0,3, 32'h5555,0,0,0,0,32'h33};
    tbl[10] = '{0,0,0,           0,0,0,       0,3, 3,3,3, 32'h77,32'h77,1,1,1,32'h77};
    tbl[11] = '{1,5,32'h1234,    0,0,0,       0,3, 7,0,0, 32'h5555,0,0,0,1,0};
    tbl[12] = '{0,0,0,           0,0,0,       0,3, 5,3,5, 32'h1234,32'h77,0,1,1,32'h1234};

    rstn = 1'b0;
    idle_a(0, 0, 0, 0);
    b_we0 = 0; b_wa0 = 0; b_wd0 = 0; b_we1 = 0; b_wa1 = 0; b_wd1 = 0;
    b_iss_vld = 0; b_iss_wa = 0; b_ra = 0; b_dbg_ra = 0;
    for (int i = 0; i < 16; i++) begin mm[i] = 0; bm[i] = 0; end
    repeat (3) @(negedge clk);
    rstn = 1'b1;

    for (int i = 0; i < 13; i++) begin
      @(negedge clk);
      drive_a(tbl[i]);
      #2;
      chk($sformatf("row%0d_rd0", i), a_rd[31:0], tbl[i].e_rd0);
      chk($sformatf("row%0d_rd1", i), a_rd[63:32], tbl[i].e_rd1);
      chk($sformatf("row%0d_busy", i), a_rd_busy, {tbl[i].e_b1, tbl[i].e_b0});
      chk($sformatf("row%0d_waw", i), a_iss_waw, tbl[i].e_waw);
      chk($sformatf("row%0d_dbg", i), a_dbg_rd, tbl[i].e_dbg);
    end

    // Mid-run reset: reg5=0x1234 and reg3 busy drop to zero immediately
    @(negedge clk);
    idle_a(5, 3, 5, 3);
    rstn = 1'b0;
    #1;
    chk("rst_rd", a_rd, 64'h0);
    chk("rst_busy", a_rd_busy, 2'b00);
    chk("rst_waw", a_iss_waw, 1'b0);
    chk("rst_dbg", a_dbg_rd, 32'h0);
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    #2;
    chk("post_rst_reg5", a_rd[31:0], 32'h0);

    // Writeback after reset lands normally
    a_we0 = 1; a_wa0 = 3; a_wd0 = 32'hBEEF;
    @(negedge clk);
    idle_a(3, 9, 3, 3);
    #2;
    chk("post_rst_wb", a_rd[31:0], 32'hBEEF);
    chk("post_rst_wb_busy", a_rd_busy[0], 1'b0);

    // Bypass: reg9 old value 0x1111, busy, then written with 0xCAFE and read same cycle
    a_we0 = 1; a_wa0 = 9; a_wd0 = 32'h1111; a_iss_vld = 1; a_iss_wa = 9;
    @(negedge clk);
    idle_a(9, 9, 9, 9);
    a_we1 = 1; a_wa1 = 9; a_wd1 = 32'hCAFE;
    #2;
`ifdef REG_FILE_BYPASS_EN
    exp_byp = 32'hCAFE; exp_bbyp = 1'b0;
`else
    exp_byp = 32'h1111; exp_bbyp = 1'b1;
`endif
    chk("byp_rd0", a_rd[31:0], exp_byp);
    chk("byp_busy0", a_rd_busy[0], exp_bbyp);
    chk("byp_dbg", a_dbg_rd, 32'h1111);
    chk("byp_waw", a_iss_waw, 1'b1);
    @(negedge clk);
    idle_a(9, 9, 9, 9);
    #2;
    chk("byp_after_rd", a_rd[31:0], 32'hCAFE);
    chk("byp_after_busy", a_rd_busy[0], 1'b0);

    // Issue and write to same busy register: busy holds in both builds, data updates
    a_iss_vld = 1; a_iss_wa = 9;
    @(negedge clk);
    idle_a(9, 9, 9, 9);
    a_iss_vld = 1; a_iss_wa = 9; a_we0 = 1; a_wa0 = 9; a_wd0 = 32'hD00D;
    #2;
    chk("tie_busy_pre", a_rd_busy[0], 1'b1);
    @(negedge clk);
    idle_a(9, 9, 9, 9);
    #2;
    chk("tie_busy_post", a_rd_busy, 2'b11);
    chk("tie_data", a_dbg_rd, 32'hD00D);

    // Random traffic on instance B against the model
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      b_we0 = 1'($urandom_range(0, 1)); b_wa0 = 4'($urandom); b_wd0 = 16'($urandom);
      b_we1 = 1'($urandom_range(0, 1)); b_wa1 = ($urandom_range(0, 3) == 0) ? b_wa0 : 4'($urandom);
      b_wd1 = 16'($urandom);
      b_iss_vld = 1'($urandom_range(0, 1));
      b_iss_wa = ($urandom_range(0, 3) == 0) ? b_wa0 : 4'($urandom);
      b_ra = 12'($urandom); b_dbg_ra = 4'($urandom);
      #2;
      for (int k = 0; k < 3; k++) begin
        chk($sformatf("rnd%0d_rd%0d", c, k), b_rd[k*16 +: 16], m_rd(b_ra[k*4 +: 4]));
        chk($sformatf("rnd%0d_busy%0d", c, k), b_rd_busy[k], m_busy(b_ra[k*4 +: 4]));
      end
      chk($sformatf("rnd%0d_waw", c), b_iss_waw, (b_iss_wa != 0) && bm[b_iss_wa]);
      chk($sformatf("rnd%0d_dbg", c), b_dbg_rd, (b_dbg_ra == 0) ? 16'h0 : mm[b_dbg_ra]);
      if (b_we0 && b_wa0 != 0) begin mm[b_wa0] = b_wd0; bm[b_wa0] = 0; end
      if (b_we1 && b_wa1 != 0) begin mm[b_wa1] = b_wd1; bm[b_wa1] = 0; end
      if (b_iss_vld && b_iss_wa != 0) bm[b_iss_wa] = 1;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
